// File: rtl/con_pkg.sv
// con_pkg: condition-code encoding shared by the branch-condition evaluator.
package con_pkg;

    typedef logic [2:0] cond_t;

    localparam cond_t COND_ZR = 3'd0;
    localparam cond_t COND_NZ = 3'd1;
    localparam cond_t COND_PL = 3'd2;
    localparam cond_t COND_MI = 3'd3;
    localparam cond_t COND_EQ = 3'd4;
    localparam cond_t COND_NE = 3'd5;
    localparam cond_t COND_LT = 3'd6;
    localparam cond_t COND_AL = 3'd7;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous reset and clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (clear || clr)
            q <= '0;
        else if (inc && !(&q))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/con_eval_unit.sv
// con_eval_unit: registered branch-condition evaluator with a reference operand
// and saturating evaluation/taken profiling counters.
module con_eval_unit
    import con_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int COND_BITS  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  CONin,
    input  logic                  REFin,
    input  logic [DATA_WIDTH-1:0] busIn,
    input  logic [COND_BITS-1:0]  IR_bits,
    input  logic                  cnt_clr,
    output logic                  CON_out,
    output logic                  con_valid,
    output logic [DATA_WIDTH-1:0] ref_q,
    output logic [CNT_WIDTH-1:0]  eval_count,
    output logic [CNT_WIDTH-1:0]  taken_count
);

    localparam int XW = COND_BITS + 3;

    logic [XW-1:0] ir_ext;
    logic          hi;
    cond_t         cond;
    logic          f;

    // Zero-extend so narrow condition fields decode and wide ones flag out-of-range codes.
    always_comb begin
        ir_ext = {3'b000, IR_bits};
        hi     = ir_ext > XW'(7);
        cond   = cond_t'(ir_ext[2:0]);
        f      = hi                ? 1'b0 :
                 cond == COND_ZR   ? busIn == '0 :
                 cond == COND_NZ   ? busIn != '0 :
                 cond == COND_PL   ? !busIn[DATA_WIDTH-1] :
                 cond == COND_MI   ? busIn[DATA_WIDTH-1] :
                 cond == COND_EQ   ? busIn == ref_q :
                 cond == COND_NE   ? busIn != ref_q :
                 cond == COND_LT   ? $signed(busIn) < $signed(ref_q) :
                 1'b1;
    end

    // The compare reads ref_q before this edge's REFin load takes effect.
    always_ff @(posedge clock) begin
        if (clear) begin
            CON_out   <= 1'b0;
            con_valid <= 1'b0;
            ref_q     <= '0;
        end else begin
            if (CONin)
                CON_out <= f;
            con_valid <= CONin;
            if (REFin)
                ref_q <= busIn;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_eval (
        .clock (clock),
        .clear (clear),
        .clr   (cnt_clr),
        .inc   (CONin),
        .q     (eval_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_taken (
        .clock (clock),
        .clear (clear),
        .clr   (cnt_clr),
        .inc   (CONin && f),
        .q     (taken_count)
    );

endmodule

// File: tb/tb_con_eval_unit.sv
// tb_con_eval_unit: directed scoreboard bench for con_eval_unit (16-bit and 2-bit counter builds).
module tb_con_eval_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        CONin = 1'b0;
    logic        REFin = 1'b0;
    logic [31:0] busIn = '0;
    logic [2:0]  IR_bits = '0;
    logic        cnt_clr = 1'b0;

    logic        con1, val1, con2, val2;
    logic [31:0] ref1, ref2;
    logic [15:0] ev1, tk1;
    logic [1:0]  ev2, tk2;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_m = '0;
    logic        con_m = 1'b0;
    logic        vld_m = 1'b0;
    int          e1 = 0, t1 = 0, e2 = 0, t2 = 0;
    logic        sb[$];

    always #5 clock = ~clock;

    con_eval_unit #(.DATA_WIDTH(32), .COND_BITS(3), .CNT_WIDTH(16)) dut (
        .clock(clock), .clear(clear), .CONin(CONin), .REFin(REFin), .busIn(busIn),
        .IR_bits(IR_bits), .cnt_clr(cnt_clr), .CON_out(con1), .con_valid(val1),
        .ref_q(ref1), .eval_count(ev1), .taken_count(tk1)
    );

    con_eval_unit #(.DATA_WIDTH(32), .COND_BITS(3), .CNT_WIDTH(2)) dut_sat (
        .clock(clock), .clear(clear), .CONin(CONin), .REFin(REFin), .busIn(busIn),
        .IR_bits(IR_bits), .cnt_clr(cnt_clr), .CON_out(con2), .con_valid(val2),
        .ref_q(ref2), .eval_count(ev2), .taken_count(tk2)
    );

    function automatic logic model_flag(input logic [31:0] b, input logic [31:0] r, input logic [2:0] ir);
        case (ir)
            3'd0:    return b == 32'd0;
            3'd1:    return b != 32'd0;
            3'd2:    return b[31] == 1'b0;
            3'd3:    return b[31] == 1'b1;
            3'd4:    return b == r;
            3'd5:    return b != r;
            3'd6:    return $signed(b) < $signed(r);
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic cv, input logic rv, input logic cc, input logic cl,
                        input logic [31:0] b, input logic [2:0] ir);
        logic fe;
        logic got;
        CONin = cv; REFin = rv; cnt_clr = cc; clear = cl; busIn = b; IR_bits = ir;
        fe = model_flag(b, ref_m, ir);
        if (cl) begin
            ref_m = '0; con_m = 1'b0; vld_m = 1'b0;
            e1 = 0; t1 = 0; e2 = 0; t2 = 0;
        end else begin
            vld_m = cv;
            if (cv) begin
                sb.push_back(fe);
                con_m = fe;
            end
            if (cc) begin
                e1 = 0; t1 = 0; e2 = 0; t2 = 0;
            end else if (cv) begin
                if (e1 < 65535) e1++;
                if (fe && t1 < 65535) t1++;
                if (e2 < 3) e2++;
                if (fe && t2 < 3) t2++;
            end
            if (rv) ref_m = b;
        end
        @(posedge clock);
        #1;
        chk("con_valid", 32'(val1), 32'(vld_m));
        chk("con_valid_w2", 32'(val2), 32'(vld_m));
        if (val1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow: observed valid pulse expected no pending evaluation");
            end else begin
                got = sb.pop_front();
                chk("con_out", 32'(con1), 32'(got));
            end
        end
        chk("con_hold", 32'(con1), 32'(con_m));
        chk("con_out_w2", 32'(con2), 32'(con_m));
        chk("ref_q", ref1, ref_m);
        chk("eval_count", 32'(ev1), 32'(e1));
        chk("taken_count", 32'(tk1), 32'(t1));
        chk("eval_count_w2", 32'(ev2), 32'(e2));
        chk("taken_count_w2", 32'(tk2), 32'(t2));
        chk("taken_le_eval", 32'(tk1 <= ev1), 32'd1);
    endtask

    initial begin
        // reset held with CONin asserted, then released
        step(1, 0, 0, 1, 32'd0, 3'd0);
        step(1, 1, 1, 1, 32'hDEAD_BEEF, 3'd7);
        chk("reset_valid", 32'(val1), 32'd0);
        step(0, 0, 0, 0, 32'd0, 3'd0);
        chk("post_reset_eval", 32'(ev1), 32'd0);
        // single-operand codes
        step(1, 0, 0, 0, 32'd0, 3'd0);
        chk("zero_taken", 32'(con1), 32'd1);
        step(1, 0, 0, 0, 32'h8000_0000, 3'd3);
        step(1, 0, 0, 0, 32'h8000_0000, 3'd2);
        chk("pl_not_taken", 32'(con1), 32'd0);
        step(0, 0, 0, 0, 32'd0, 3'd7);
        // reference compares
        step(0, 1, 0, 0, 32'd5, 3'd0);
        step(1, 0, 0, 0, 32'd5, 3'd4);
        chk("eq_ref", 32'(con1), 32'd1);
        step(1, 0, 0, 0, 32'hFFFF_FFFF, 3'd6);
        chk("lt_signed", 32'(con1), 32'd1);
        step(1, 1, 0, 0, 32'd7, 3'd4);
        chk("eq_old_ref", 32'(con1), 32'd0);
        step(0, 0, 0, 0, 32'd0, 3'd0);
        chk("ref_new", ref1, 32'd7);
        // back-to-back evaluations
        step(0, 0, 1, 0, 32'd0, 3'd0);
        step(1, 0, 0, 0, 32'd0, 3'd7);
        step(1, 0, 0, 0, 32'd0, 3'd7);
        step(1, 0, 0, 0, 32'd0, 3'd1);
        step(1, 0, 0, 0, 32'd0, 3'd0);
        chk("b2b_eval", 32'(ev1), 32'd4);
        chk("b2b_taken", 32'(tk1), 32'd3);
        // saturation of the 2-bit build
        step(0, 0, 1, 0, 32'd0, 3'd0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 32'd0, 3'd7);
        chk("sat_eval", 32'(ev2), 32'd3);
        chk("sat_taken", 32'(tk2), 32'd3);
        chk("nosat_eval", 32'(ev1), 32'd5);
        // counter clear beats increment
        step(1, 0, 1, 0, 32'd0, 3'd7);
        chk("clr_eval", 32'(ev1), 32'd0);
        chk("clr_con", 32'(con1), 32'd1);
        // random mix
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                 1'b0, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 3'($urandom_range(0, 7)));
        // reset on the same edge as an evaluation
        step(1, 0, 0, 1, 32'd0, 3'd7);
        chk("mid_reset_valid", 32'(val1), 32'd0);
        chk("mid_reset_con", 32'(con1), 32'd0);
        step(0, 0, 0, 0, 32'd0, 3'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
